// File: rtl/mux_arb_pkg.sv
// Shared types and widths for the round-robin mux arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [N_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping 3->0.
// Latency: combinational.
// Backpressure: n/a; hit_o low when no request is set.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             hit_o
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        cand  = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = ptr_i + SEL_W'(k);
            if (req_i[cand]) begin
                idx_o = cand;
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the 4:1 mux select with a bounded ownership quantum.
// Latency: grant/sel one edge after req sampled; one GAP cycle between owners.
// Backpressure: owner holds while req stays high; forced off after QUANTUM cycles if contended.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int QUANTUM = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] req_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [N_SRC-1:0] grant_o,
    output logic             busy_o,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);

    state_t           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [N_SRC-1:0] grant_q;
    logic             busy_q;
    logic             expired_q;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_hit;
    logic             rel_vol;
    logic             rel_forced;

    rr_pick u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .hit_o (pick_hit)
    );

    // A voluntary drop takes precedence, so expiry coinciding with a drop is not flagged.
    always_comb begin
        rel_vol    = ~req_i[owner_q];
        rel_forced = (cnt_q == QMAX) && ((req_i & ~onehot(owner_q)) != '0);
        cnt_d      = (cnt_q == QMAX) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OWN: begin
                    if (rel_vol || rel_forced) begin
                        state_q   <= ST_GAP;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= owner_q + 1'b1;
                        expired_q <= ~rel_vol;
                    end else begin
                        cnt_q     <= cnt_d;
                        expired_q <= 1'b0;
                    end
                end
                default: begin
                    expired_q <= 1'b0;
                    if (pick_hit) begin
                        state_q <= ST_OWN;
                        owner_q <= pick_idx;
                        sel_q   <= pick_idx;
                        grant_q <= onehot(pick_idx);
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign sel_o     = sel_q;
    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign expired_o = expired_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter against an ownership-level reference model.
module tb_mux_rr_arbiter;

    localparam int Q = 8;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] req_i;
    logic [1:0] sel_o;
    logic [3:0] grant_o;
    logic       busy_o;
    logic       expired_o;
    logic [7:0] obs;

    int errors;
    int checks;

    // Reference model: who owns, for how long, and who is next in line.
    int m_own;
    int m_ptr;
    int m_held;
    int m_sel;
    bit m_exp;

    mux_rr_arbiter #(.QUANTUM(Q)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .sel_o     (sel_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .expired_o (expired_o)
    );

    assign obs = {grant_o, sel_o, busy_o, expired_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_exp = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        bit vol;
        bit others;
        if (m_own >= 0) begin
            vol    = !r[m_own];
            others = (r & ~(4'b0001 << m_own)) != 4'b0000;
            if (vol || (m_held >= Q && others)) begin
                m_exp = !vol;
                m_ptr = (m_own + 1) % 4;
                m_own = -1;
            end else begin
                m_exp = 0;
                if (m_held < Q) m_held++;
            end
        end else begin
            m_exp = 0;
            for (int k = 0; k < 4; k++)
                if (m_own < 0 && r[(m_ptr + k) % 4]) m_own = (m_ptr + k) % 4;
            if (m_own >= 0) begin
                m_sel  = m_own;
                m_held = 1;
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
        return {g, 2'(m_sel), (m_own >= 0), m_exp};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        model_step(req_i);
        #2;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        req_i = 4'b0000;
        rst_ni = 1'b0;
        model_reset();
        #3;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs, 8'b0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        req_i = 4'b0100;
        tick();
        checks++;
        if (obs !== {4'b0100, 2'b10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant got=%b want=%b", obs, {4'b0100, 2'b10, 1'b1, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_hold[%0d] got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_all_req();
        int n_exp;
        int order[$];
        logic prev_g;
        int want_order[5];
        want_order = '{0, 1, 2, 3, 0};
        n_exp = 0;
        prev_g = 1'b0;
        apply_reset();
        req_i = 4'b1111;
        for (int i = 0; i < 37; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL all_req[%0d] got=%b want=%b", i, obs, exp_vec());
            end
            if (expired_o === 1'b1) n_exp++;
            if (grant_o != 4'b0 && !prev_g) order.push_back(int'(sel_o));
            prev_g = (grant_o != 4'b0);
        end
        checks++;
        if (n_exp != 4) begin
            errors++;
            $display("FAIL all_req_expired_count got=%0d want=4", n_exp);
        end
        checks++;
        if (order.size() != 5) begin
            errors++;
            $display("FAIL all_req_owner_count got=%0d want=5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != want_order[i]) begin
                    errors++;
                    $display("FAIL all_req_order[%0d] got=%0d want=%0d", i, order[i], want_order[i]);
                end
            end
        end
    endtask

    task automatic test_lone();
        apply_reset();
        req_i = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== {4'b0010, 2'b01, 1'b1, 1'b0} || obs !== exp_vec()) begin
                errors++;
                $display("FAIL lone_hold[%0d] got=%b want=%b", i, obs, {4'b0010, 2'b01, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_simul_drop();
        apply_reset();
        req_i = 4'b1001;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (obs !== {4'b0001, 2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drop_pre got=%b want=%b", obs, {4'b0001, 2'b00, 1'b1, 1'b0});
        end
        req_i = 4'b1000;
        tick();
        checks++;
        if (obs !== {4'b0000, 2'b00, 1'b0, 1'b0} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL drop_gap got=%b want=%b", obs, {4'b0000, 2'b00, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {4'b1000, 2'b11, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drop_next got=%b want=%b", obs, {4'b1000, 2'b11, 1'b1, 1'b0});
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        req_i = 4'b0010;
        tick();
        req_i = 4'b0000;
        tick();
        req_i = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (obs !== {4'b0100, 2'b10, 1'b1, 1'b0} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_pre got=%b want=%b", obs, exp_vec());
        end
        rst_ni = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 8'b0) begin
            errors++;
            $display("FAIL midrst_async got=%b want=%b", obs, 8'b0);
        end
        req_i = 4'b0110;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++;
        if (obs !== {4'b0010, 2'b01, 1'b1, 1'b0} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_first got=%b want=%b", obs, {4'b0010, 2'b01, 1'b1, 1'b0});
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        req_i = 4'b1000;
        for (int i = 0; i < 3; i++) tick();
        req_i = 4'b0000;
        tick();
        req_i = 4'b1001;
        tick();
        checks++;
        if (obs !== {4'b0001, 2'b00, 1'b1, 1'b0} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_grant0 got=%b want=%b", obs, {4'b0001, 2'b00, 1'b1, 1'b0});
        end
        tick();
        tick();
        req_i = 4'b1000;
        tick();
        tick();
        checks++;
        if (obs !== {4'b1000, 2'b11, 1'b1, 1'b0} || obs !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_grant3 got=%b want=%b", obs, {4'b1000, 2'b11, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        apply_reset();
        req_i = 4'($urandom);
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) req_i[b] = ~req_i[b];
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d] req=%b got=%b want=%b", i, req_i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        req_i  = 4'b0000;
        rst_ni = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_all_req();
        test_lone();
        test_simul_drop();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
